// File: rtl/pe_blend_pkg.sv
// Shared types and constants for the GBA colour special-effects stage.
// Coefficient clamp and target-bit lookup helpers live here so decode stays readable.
package pe_blend_pkg;

  localparam int CW     = 5;
  localparam int EVW    = 5;
  localparam int EV_MAX = 16;
  localparam int CH_MAX = 31;

  typedef enum logic [2:0] {
    L_BG0 = 3'd0,
    L_BG1 = 3'd1,
    L_BG2 = 3'd2,
    L_BG3 = 3'd3,
    L_OBJ = 3'd4,
    L_BD  = 3'd5
  } layer_t;

  typedef enum logic [1:0] {
    BM_NONE       = 2'd0,
    BM_ALPHA      = 2'd1,
    BM_BRIGHT_INC = 2'd2,
    BM_BRIGHT_DEC = 2'd3
  } blend_mode_t;

  typedef struct packed {
    logic [4:0] b;
    logic [4:0] g;
    logic [4:0] r;
  } rgb555_t;

  function automatic logic [EVW-1:0] ev_clamp(input logic [EVW-1:0] ev);
    return (ev > EVW'(EV_MAX)) ? EVW'(EV_MAX) : ev;
  endfunction

  // Layer codes 6/7 do not exist, so they never hit a target bit.
  function automatic logic is_target(input logic [5:0] mask, input logic [2:0] layer);
    logic [7:0] m;
    m = {2'b00, mask};
    return m[layer];
  endfunction

endpackage

// File: rtl/pe_blend_if.sv
// Pixel-in / pixel-out bus of the blend stage, plus the per-pixel effect configuration.
// slave = blend unit view, master = priority-evaluation / line-buffer view.
interface pe_blend_if;
  import pe_blend_pkg::*;

  logic        in_valid;
  logic        in_ready;
  rgb555_t     top_color;
  layer_t      top_layer;
  logic        top_obj_semi;
  rgb555_t     bot_color;
  layer_t      bot_layer;
  logic        win_fx_en;
  logic [13:0] bldcnt;
  logic [12:0] bldalpha;
  logic [4:0]  bldy;
  logic        line_start;
  logic        out_valid;
  logic        out_ready;
  rgb555_t     out_color;

  modport slave (
    input  in_valid, top_color, top_layer, top_obj_semi, bot_color, bot_layer,
           win_fx_en, bldcnt, bldalpha, bldy, line_start, out_ready,
    output in_ready, out_valid, out_color
  );

  modport master (
    output in_valid, top_color, top_layer, top_obj_semi, bot_color, bot_layer,
           win_fx_en, bldcnt, bldalpha, bldy, line_start, out_ready,
    input  in_ready, out_valid, out_color
  );

endinterface

// File: rtl/pe_blend_channel.sv
// One colour channel of the blend datapath: S2 products and S3 sum/saturate, both combinational;
// the pipeline registers between them sit in the top, so backpressure is handled there.
module pe_blend_channel
  import pe_blend_pkg::*;
#(
  parameter int CW  = 5,
  parameter int EVW = 5
) (
  input  blend_mode_t       s1_mode,
  input  logic [CW-1:0]     s1_top,
  input  logic [CW-1:0]     s1_bot,
  input  logic [EVW-1:0]    s1_eva,
  input  logic [EVW-1:0]    s1_evb,
  input  logic [EVW-1:0]    s1_evy,
  output logic [CW+EVW-1:0] s1_p1,
  output logic [CW+EVW-1:0] s1_p2,
  input  blend_mode_t       s2_mode,
  input  logic [CW-1:0]     s2_top,
  input  logic [CW+EVW-1:0] s2_p1,
  input  logic [CW+EVW-1:0] s2_p2,
  output logic [CW-1:0]     s2_res
);

  localparam int            PW   = CW + EVW;
  localparam int            SH   = $clog2(EV_MAX);
  localparam logic [CW-1:0] MAXV = CW'(CH_MAX);

  function automatic logic [PW-1:0] mul(input logic [CW-1:0] c, input logic [EVW-1:0] k);
    return PW'(c) * PW'(k);
  endfunction

  logic [PW:0]   sum;
  logic [PW:0]   sum_sh;
  logic [CW-1:0] p1_sh;

  always_comb begin
    s1_p1 = '0;
    s1_p2 = '0;
    case (s1_mode)
      BM_ALPHA: begin
        s1_p1 = mul(s1_top, s1_eva);
        s1_p2 = mul(s1_bot, s1_evb);
      end
      BM_BRIGHT_INC: s1_p1 = mul(MAXV - s1_top, s1_evy);
      BM_BRIGHT_DEC: s1_p1 = mul(s1_top, s1_evy);
      default: ;
    endcase
  end

  // Brightness terms are bounded by the headroom (or the value), so only alpha can saturate.
  always_comb begin
    sum    = {1'b0, s2_p1} + {1'b0, s2_p2};
    sum_sh = sum >> SH;
    p1_sh  = CW'(s2_p1 >> SH);
    s2_res = s2_top;
    case (s2_mode)
      BM_ALPHA:      s2_res = (sum_sh > (PW+1)'(MAXV)) ? MAXV : sum_sh[CW-1:0];
      BM_BRIGHT_INC: s2_res = s2_top + p1_sh;
      BM_BRIGHT_DEC: s2_res = s2_top - p1_sh;
      default: ;
    endcase
  end

endmodule

// File: rtl/pe_blend_unit.sv
// GBA colour special effects (alpha, brighten, darken, semi-transparent OBJ); PE_BLEND_LINE_LATCH_EN latches config per line.
// Latency 3 cycles, 1 pixel/cycle; whole pipe stalls together while out_valid is held against out_ready low.
module pe_blend_unit
  import pe_blend_pkg::*;
#(
  parameter int CW  = 5,
  parameter int EVW = 5
) (
  input logic       clk,
  input logic       rst,
  pe_blend_if.slave bus
);

  logic        advance;
  logic [13:0] cnt_sel;
  logic [12:0] alpha_sel;
  logic [4:0]  y_sel;
  logic        unused_cfg;

`ifdef PE_BLEND_LINE_LATCH_EN
  logic [13:0] cnt_sh;
  logic [12:0] alpha_sh;
  logic [4:0]  y_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_sh   <= '0;
      alpha_sh <= '0;
      y_sh     <= '0;
    end else if (bus.line_start) begin
      cnt_sh   <= bus.bldcnt;
      alpha_sh <= bus.bldalpha;
      y_sh     <= bus.bldy;
    end
  end

  // A pixel arriving with line_start already belongs to the new line.
  assign cnt_sel    = bus.line_start ? bus.bldcnt   : cnt_sh;
  assign alpha_sel  = bus.line_start ? bus.bldalpha : alpha_sh;
  assign y_sel      = bus.line_start ? bus.bldy     : y_sh;
  assign unused_cfg = ^alpha_sel[7:5];
`else
  assign cnt_sel    = bus.bldcnt;
  assign alpha_sel  = bus.bldalpha;
  assign y_sel      = bus.bldy;
  assign unused_cfg = ^{alpha_sel[7:5], bus.line_start};
`endif

  logic [2:0]  tl;
  logic [2:0]  bl;
  logic        top_tgt;
  logic        bot_tgt;
  blend_mode_t cfg_mode;
  blend_mode_t mode_d;

  assign tl       = bus.top_layer;
  assign bl       = bus.bot_layer;
  assign top_tgt  = is_target(cnt_sel[5:0], tl);
  assign bot_tgt  = is_target(cnt_sel[13:8], bl);
  assign cfg_mode = blend_mode_t'(cnt_sel[7:6]);

  // Window disable beats everything; semi-transparent OBJ forces alpha regardless of mode.
  always_comb begin
    mode_d = BM_NONE;
    if (!bus.win_fx_en) begin
      mode_d = BM_NONE;
    end else if (bus.top_obj_semi && bot_tgt) begin
      mode_d = BM_ALPHA;
    end else if (top_tgt) begin
      case (cfg_mode)
        BM_ALPHA:      mode_d = bot_tgt ? BM_ALPHA : BM_NONE;
        BM_BRIGHT_INC: mode_d = BM_BRIGHT_INC;
        BM_BRIGHT_DEC: mode_d = BM_BRIGHT_DEC;
        default:       mode_d = BM_NONE;
      endcase
    end
  end

  logic               s1_vld;
  blend_mode_t        s1_mode;
  rgb555_t            s1_top;
  rgb555_t            s1_bot;
  logic [EVW-1:0]     s1_eva;
  logic [EVW-1:0]     s1_evb;
  logic [EVW-1:0]     s1_evy;
  logic               s2_vld;
  blend_mode_t        s2_mode;
  rgb555_t            s2_top;
  logic [CW+EVW-1:0]  s2_p1 [3];
  logic [CW+EVW-1:0]  s2_p2 [3];
  logic               s3_vld;
  rgb555_t            s3_color;
  logic [CW+EVW-1:0]  p1_c [3];
  logic [CW+EVW-1:0]  p2_c [3];
  logic [3*CW-1:0]    res_c;

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    pe_blend_channel #(.CW(CW), .EVW(EVW)) u_ch (
      .s1_mode (s1_mode),
      .s1_top  (s1_top[ch*CW +: CW]),
      .s1_bot  (s1_bot[ch*CW +: CW]),
      .s1_eva  (s1_eva),
      .s1_evb  (s1_evb),
      .s1_evy  (s1_evy),
      .s1_p1   (p1_c[ch]),
      .s1_p2   (p2_c[ch]),
      .s2_mode (s2_mode),
      .s2_top  (s2_top[ch*CW +: CW]),
      .s2_p1   (s2_p1[ch]),
      .s2_p2   (s2_p2[ch]),
      .s2_res  (res_c[ch*CW +: CW])
    );
  end

  assign advance       = !s3_vld || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = s3_vld;
  assign bus.out_color = s3_color;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_mode  <= BM_NONE;
      s1_top   <= '0;
      s1_bot   <= '0;
      s1_eva   <= '0;
      s1_evb   <= '0;
      s1_evy   <= '0;
      s2_vld   <= 1'b0;
      s2_mode  <= BM_NONE;
      s2_top   <= '0;
      for (int i = 0; i < 3; i++) begin
        s2_p1[i] <= '0;
        s2_p2[i] <= '0;
      end
      s3_vld   <= 1'b0;
      s3_color <= '0;
    end else if (advance) begin
      s1_vld <= bus.in_valid;
      if (bus.in_valid) begin
        s1_mode <= mode_d;
        s1_top  <= bus.top_color;
        s1_bot  <= bus.bot_color;
        s1_eva  <= ev_clamp(alpha_sel[4:0]);
        s1_evb  <= ev_clamp(alpha_sel[12:8]);
        s1_evy  <= ev_clamp(y_sel);
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_mode <= s1_mode;
        s2_top  <= s1_top;
        s2_p1   <= p1_c;
        s2_p2   <= p2_c;
      end
      s3_vld <= s2_vld;
      if (s2_vld) begin
        s3_color <= res_c;
      end
    end
  end

endmodule

// File: tb/tb_pe_blend_unit.sv
// Directed and randomized bench for pe_blend_unit against an arithmetic reference model.
// Works with or without PE_BLEND_LINE_LATCH_EN defined.
module tb_pe_blend_unit;
  import pe_blend_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_blend_if bus();

  pe_blend_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [14:0] top;
    logic [14:0] bot;
    logic [2:0]  tl;
    logic [2:0]  bl;
    logic        semi;
    logic        win;
    logic [13:0] cnt;
    logic [12:0] alpha;
    logic [4:0]  y;
    logic        ls;
  } px_t;

  int          checks   = 0;
  int          failures = 0;
  logic [14:0] exp_q [$];
  logic [14:0] last_out = '0;
  logic [13:0] sh_cnt   = '0;
  logic [12:0] sh_alpha = '0;
  logic [4:0]  sh_y     = '0;
  bit          stall_prev = 1'b0;
  logic [14:0] held = '0;
  bit          done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: GBA blend rules evaluated with integer arithmetic per channel.
  function automatic logic [14:0] ref_px(input px_t p, input logic [13:0] cnt,
                                         input logic [12:0] al, input logic [4:0] y);
    int eva, evb, evy, t, b, r, mode;
    bit top_t, bot_t;
    logic [14:0] res;
    eva = int'(al[4:0]);  if (eva > 16) eva = 16;
    evb = int'(al[12:8]); if (evb > 16) evb = 16;
    evy = int'(y);        if (evy > 16) evy = 16;
    top_t = (p.tl <= 3'd5) ? cnt[p.tl] : 1'b0;
    bot_t = (p.bl <= 3'd5) ? cnt[8 + p.bl] : 1'b0;
    if (!p.win) mode = 0;
    else if (p.semi && bot_t) mode = 1;
    else if (!top_t) mode = 0;
    else begin
      case (cnt[7:6])
        2'd1:    mode = bot_t ? 1 : 0;
        2'd2:    mode = 2;
        2'd3:    mode = 3;
        default: mode = 0;
      endcase
    end
    res = p.top;
    for (int ch = 0; ch < 3; ch++) begin
      t = int'((p.top >> (5*ch)) & 15'd31);
      b = int'((p.bot >> (5*ch)) & 15'd31);
      case (mode)
        1: begin r = (t*eva + b*evb) / 16; if (r > 31) r = 31; end
        2: r = t + ((31 - t) * evy) / 16;
        3: r = t - (t * evy) / 16;
        default: r = t;
      endcase
      res[5*ch +: 5] = r[4:0];
    end
    return res;
  endfunction

  function automatic px_t mk(input logic [14:0] top, input logic [14:0] bot, input int tl, input int bl,
                             input bit semi, input bit win, input logic [13:0] cnt,
                             input logic [12:0] alpha, input logic [4:0] y, input bit ls);
    px_t p;
    p.top = top; p.bot = bot; p.tl = 3'(tl); p.bl = 3'(bl); p.semi = semi; p.win = win;
    p.cnt = cnt; p.alpha = alpha; p.y = y; p.ls = ls;
    return p;
  endfunction

  function automatic px_t rand_px();
    px_t p;
    p.top   = 15'($urandom);
    p.bot   = 15'($urandom);
    p.tl    = 3'($urandom_range(0, 5));
    p.bl    = 3'($urandom_range(0, 5));
    p.semi  = 1'($urandom_range(0, 1));
    p.win   = ($urandom_range(0, 7) != 0);
    p.cnt   = 14'($urandom);
    p.alpha = 13'($urandom);
    p.y     = 5'($urandom);
    p.ls    = 1'b0;
    return p;
  endfunction

  task automatic send(input px_t p);
    int n;
    bit acc;
    logic [14:0] e;
    bus.top_color    = p.top;
    bus.bot_color    = p.bot;
    bus.top_layer    = layer_t'(p.tl);
    bus.bot_layer    = layer_t'(p.bl);
    bus.top_obj_semi = p.semi;
    bus.win_fx_en    = p.win;
    bus.bldcnt       = p.cnt;
    bus.bldalpha     = p.alpha;
    bus.bldy         = p.y;
    bus.line_start   = p.ls;
    bus.in_valid     = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept", 32'(acc), 32'd1);
    if (acc) begin
`ifdef PE_BLEND_LINE_LATCH_EN
      if (p.ls) begin
        sh_cnt = p.cnt; sh_alpha = p.alpha; sh_y = p.y;
      end
      e = ref_px(p, sh_cnt, sh_alpha, sh_y);
`else
      e = ref_px(p, p.cnt, p.alpha, p.y);
`endif
      exp_q.push_back(e);
    end
    bus.in_valid   = 1'b0;
    bus.line_start = 1'b0;
  endtask

  task automatic pulse_line(input logic [13:0] cnt, input logic [12:0] alpha, input logic [4:0] y);
    bus.bldcnt     = cnt;
    bus.bldalpha   = alpha;
    bus.bldy       = y;
    bus.line_start = 1'b1;
    bus.in_valid   = 1'b0;
    @(posedge clk);
    #1;
    bus.line_start = 1'b0;
`ifdef PE_BLEND_LINE_LATCH_EN
    sh_cnt = cnt; sh_alpha = alpha; sh_y = y;
`endif
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Output monitor: ordering/values against the model, plus stall behaviour.
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev) begin
        chk("stall_hold_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_hold_color", 32'(bus.out_color), 32'(held));
      end
      if (bus.out_valid && !bus.out_ready)
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(bus.out_valid), 32'd0);
        end else begin
          chk("out_color", 32'(bus.out_color), 32'(exp_q.pop_front()));
          last_out = bus.out_color;
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held       = bus.out_color;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

`ifdef PE_BLEND_LINE_LATCH_EN
  localparam logic [4:0] T6_MID = 5'd7;
  localparam logic [4:0] T6_NEW = 5'd31;
`else
  localparam logic [4:0] T6_MID = 5'd31;
  localparam logic [4:0] T6_NEW = 5'd3;
`endif

  initial begin
    int lat;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.line_start = 1'b0;
    bus.top_color = '0; bus.bot_color = '0; bus.top_layer = L_BG0; bus.bot_layer = L_BG0;
    bus.top_obj_semi = 1'b0; bus.win_fx_en = 1'b0;
    bus.bldcnt = '0; bus.bldalpha = '0; bus.bldy = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_color", 32'(bus.out_color), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // Alpha 8/8 on full red, plus accept->out_valid latency.
    send(mk({5'd3, 5'd9, 5'd31}, {5'd12, 5'd1, 5'd31}, 0, 1, 0, 1, 14'h241, {5'd8, 3'd0, 5'd8}, 5'd0, 0));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 10);
    chk("t1_latency", 32'(lat), 32'd3);
    drain();
    chk("t1_alpha_r", 32'(last_out[4:0]), 32'd31);

    send(mk({5'd5, 5'd6, 5'd20}, {5'd7, 5'd8, 5'd20}, 0, 1, 0, 1, 14'h241, {5'd16, 3'd0, 5'd20}, 5'd0, 0));
    drain();
    chk("t2_alpha_sat", 32'(last_out[4:0]), 32'd31);
    send(mk({5'd5, 5'd6, 5'd20}, {5'd7, 5'd8, 5'd20}, 0, 1, 0, 1, 14'h241, {5'd4, 3'd0, 5'd4}, 5'd0, 0));
    drain();
    chk("t2_alpha_4_4", 32'(last_out[4:0]), 32'd10);

    send(mk({5'd2, 5'd2, 5'd0}, 15'd0, 0, 1, 0, 1, 14'h081, 13'd0, 5'd16, 0));
    drain();
    chk("t3_inc", 32'(last_out[4:0]), 32'd31);
    send(mk({5'd2, 5'd2, 5'd31}, 15'd0, 0, 1, 0, 1, 14'h0C1, 13'd0, 5'd8, 0));
    drain();
    chk("t3_dec", 32'(last_out[4:0]), 32'd16);
    send(mk({5'd2, 5'd2, 5'd7}, 15'd0, 0, 1, 0, 1, 14'h080, 13'd0, 5'd16, 0));
    drain();
    chk("t3_no_target", 32'(last_out), 32'({5'd2, 5'd2, 5'd7}));

    send(mk({5'd1, 5'd1, 5'd10}, {5'd3, 5'd3, 5'd20}, 4, 2, 1, 1, 14'h400, {5'd8, 3'd0, 5'd8}, 5'd0, 0));
    drain();
    chk("t4_semi_obj", 32'(last_out[4:0]), 32'd15);
    send(mk({5'd1, 5'd1, 5'd10}, {5'd3, 5'd3, 5'd20}, 4, 2, 1, 0, 14'h400, {5'd8, 3'd0, 5'd8}, 5'd0, 0));
    drain();
    chk("t4_win_off", 32'(last_out[4:0]), 32'd10);

    // Stream with a three-cycle output stall once the pipe is full.
    fork
      begin
        for (int i = 0; i < 8; i++) send(rand_px());
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three pixels in flight.
    for (int i = 0; i < 3; i++) send(rand_px());
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Config change mid-line.
    pulse_line(14'h081, 13'd0, 5'd4);
    send(mk({5'd0, 5'd0, 5'd0}, 15'd0, 0, 1, 0, 1, 14'h081, 13'd0, 5'd4, 0));
    drain();
    chk("t6_base", 32'(last_out[4:0]), 32'd7);
    send(mk({5'd0, 5'd0, 5'd0}, 15'd0, 0, 1, 0, 1, 14'h081, 13'd0, 5'd16, 0));
    drain();
    chk("t6_midline", 32'(last_out[4:0]), 32'(T6_MID));
    pulse_line(14'h081, 13'd0, 5'd16);
    send(mk({5'd0, 5'd0, 5'd0}, 15'd0, 0, 1, 0, 1, 14'h081, 13'd0, 5'd2, 0));
    drain();
    chk("t6_newline", 32'(last_out[4:0]), 32'(T6_NEW));

    // Random traffic with random backpressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) send(rand_px());
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
